// File: rtl/dmem_ls_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dmem_ls_arbiter_pkg                                              |
// | Brief   : funct3 codes, FSM encoding and request checks for the LS arbiter |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package dmem_ls_arbiter_pkg;

   localparam logic [2:0] c_f3_lb  = 3'b000;
   localparam logic [2:0] c_f3_lh  = 3'b001;
   localparam logic [2:0] c_f3_lw  = 3'b010;
   localparam logic [2:0] c_f3_lbu = 3'b100;
   localparam logic [2:0] c_f3_lhu = 3'b101;
   localparam logic [2:0] c_f3_sb  = 3'b000;
   localparam logic [2:0] c_f3_sh  = 3'b001;
   localparam logic [2:0] c_f3_sw  = 3'b010;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_READ   = 3'd1,
      S_WRITE  = 3'd2,
      S_RMW_RD = 3'd3,
      S_RMW_WR = 3'd4,
      S_RESP   = 3'd5
   } state_t;

   function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
      if (we)
         return !(f3 == c_f3_sb || f3 == c_f3_sh || f3 == c_f3_sw);
      else
         return !(f3 == c_f3_lb || f3 == c_f3_lh || f3 == c_f3_lw ||
                  f3 == c_f3_lbu || f3 == c_f3_lhu);
   endfunction

   // funct3[1:0] encodes the access size for both loads and stores
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b01:   return off[0];
         2'b10:   return off != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_subword_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dmem_subword_unit                                                |
// | Brief   : load lane extract/extend and store byte/half merge (32b words)   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dmem_subword_unit #(
   parameter int REG_WIDTH = 32
) (
   input  logic [2:0]           funct3,
   input  logic [1:0]           byte_off,
   input  logic [REG_WIDTH-1:0] load_word,
   output logic [REG_WIDTH-1:0] load_data,
   input  logic [REG_WIDTH-1:0] merge_word,
   input  logic [REG_WIDTH-1:0] store_data,
   output logic [REG_WIDTH-1:0] merge_data
);
   import dmem_ls_arbiter_pkg::*;

   logic [4:0]           w_shamt;
   logic [15:0]          w_lane;
   logic [REG_WIDTH-1:0] w_mask;
   logic [REG_WIDTH-1:0] w_ins;

   assign w_shamt = {byte_off, 3'b000};
   assign w_lane  = 16'(load_word >> w_shamt);

   always_comb begin
      load_data = '0;
      case (funct3)
         c_f3_lb:  load_data = {{(REG_WIDTH-8){w_lane[7]}}, w_lane[7:0]};
         c_f3_lh:  load_data = {{(REG_WIDTH-16){w_lane[15]}}, w_lane};
         c_f3_lw:  load_data = load_word;
         c_f3_lbu: load_data = {{(REG_WIDTH-8){1'b0}}, w_lane[7:0]};
         c_f3_lhu: load_data = {{(REG_WIDTH-16){1'b0}}, w_lane};
         default:  load_data = '0;
      endcase
   end

   always_comb begin
      w_mask = '1;
      w_ins  = store_data;
      case (funct3)
         c_f3_sb: begin
            w_mask = {{(REG_WIDTH-8){1'b0}}, 8'hFF} << w_shamt;
            w_ins  = {{(REG_WIDTH-8){1'b0}}, store_data[7:0]} << w_shamt;
         end
         c_f3_sh: begin
            w_mask = {{(REG_WIDTH-16){1'b0}}, 16'hFFFF} << w_shamt;
            w_ins  = {{(REG_WIDTH-16){1'b0}}, store_data[15:0]} << w_shamt;
         end
         default: ;
      endcase
   end

   assign merge_data = (merge_word & ~w_mask) | (w_ins & w_mask);

endmodule
`default_nettype wire

// File: rtl/dmem_ls_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dmem_ls_arbiter                                                  |
// | Brief   : round-robin two-port RV32 load/store controller for word DMEM    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dmem_ls_arbiter #(
   parameter int REG_WIDTH       = 32,
   parameter int DMEM_ADDR_WIDTH = 10,
   parameter int DMEM_DEPTH      = 1024
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       m0_req,
   input  logic                       m0_we,
   input  logic [2:0]                 m0_funct3,
   input  logic [DMEM_ADDR_WIDTH-1:0] m0_addr,
   input  logic [REG_WIDTH-1:0]       m0_wdata,
   output logic                       m0_done,
   output logic [REG_WIDTH-1:0]       m0_rdata,
   output logic                       m0_err,
   input  logic                       m1_req,
   input  logic                       m1_we,
   input  logic [2:0]                 m1_funct3,
   input  logic [DMEM_ADDR_WIDTH-1:0] m1_addr,
   input  logic [REG_WIDTH-1:0]       m1_wdata,
   output logic                       m1_done,
   output logic [REG_WIDTH-1:0]       m1_rdata,
   output logic                       m1_err,
   output logic                       dmem_wr_en,
   output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
   output logic [REG_WIDTH-1:0]       dmem_wr_data,
   input  logic [REG_WIDTH-1:0]       dmem_rd_data
);
   import dmem_ls_arbiter_pkg::*;

   localparam logic [31:0] c_addr_max = 32'(DMEM_DEPTH - 4);

   state_t                     r_state;
   logic                       r_gnt;
   logic                       r_rr_last;
   logic                       r_we;
   logic                       r_err;
   logic [2:0]                 r_funct3;
   logic [DMEM_ADDR_WIDTH-1:0] r_addr;
   logic [REG_WIDTH-1:0]       r_wdata;
   logic [REG_WIDTH-1:0]       r_word;
   logic [REG_WIDTH-1:0]       r_rdata;

   logic                       w_sel;
   logic                       w_any;
   logic                       w_we;
   logic [2:0]                 w_f3;
   logic [DMEM_ADDR_WIDTH-1:0] w_addr;
   logic [REG_WIDTH-1:0]       w_wdata;
   logic                       w_err;
   logic [REG_WIDTH-1:0]       w_load_data;
   logic [REG_WIDTH-1:0]       w_merge_data;

   // On a tie the requester that was not served last wins
   assign w_sel   = m0_req ? (m1_req & ~r_rr_last) : m1_req;
   assign w_any   = m0_req | m1_req;
   assign w_we    = w_sel ? m1_we     : m0_we;
   assign w_f3    = w_sel ? m1_funct3 : m0_funct3;
   assign w_addr  = w_sel ? m1_addr   : m0_addr;
   assign w_wdata = w_sel ? m1_wdata  : m0_wdata;
   assign w_err   = f3_illegal(w_we, w_f3) | misaligned(w_f3, w_addr[1:0]) |
                    (32'(w_addr) > c_addr_max);

   dmem_subword_unit #(
      .REG_WIDTH (REG_WIDTH)
   ) u_subword (
      .funct3     (r_funct3),
      .byte_off   (r_addr[1:0]),
      .load_word  (dmem_rd_data),
      .load_data  (w_load_data),
      .merge_word (r_word),
      .store_data (r_wdata),
      .merge_data (w_merge_data)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_gnt     <= 1'b0;
         r_rr_last <= 1'b1;
         r_we      <= 1'b0;
         r_err     <= 1'b0;
         r_funct3  <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_word    <= '0;
         r_rdata   <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_any) begin
               r_gnt    <= w_sel;
               r_we     <= w_we;
               r_funct3 <= w_f3;
               r_addr   <= w_addr;
               r_wdata  <= w_wdata;
               r_err    <= w_err;
               r_rdata  <= '0;
               if (w_err)              r_state <= S_RESP;
               else if (!w_we)         r_state <= S_READ;
               else if (w_f3 == c_f3_sw) r_state <= S_WRITE;
               else                    r_state <= S_RMW_RD;
            end
            S_READ: begin
               r_rdata <= w_load_data;
               r_state <= S_RESP;
            end
            S_RMW_RD: begin
               r_word  <= dmem_rd_data;
               r_state <= S_RMW_WR;
            end
            S_WRITE, S_RMW_WR: r_state <= S_RESP;
            S_RESP: begin
               r_rr_last <= r_gnt;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Outputs decode registered state only, so an async reset clears them at once
   assign m0_done      = (r_state == S_RESP) & ~r_gnt;
   assign m1_done      = (r_state == S_RESP) &  r_gnt;
   assign m0_rdata     = m0_done ? r_rdata : '0;
   assign m1_rdata     = m1_done ? r_rdata : '0;
   assign m0_err       = m0_done & r_err;
   assign m1_err       = m1_done & r_err;
   assign dmem_wr_en   = (r_state == S_WRITE) | (r_state == S_RMW_WR);
   assign dmem_addr    = {r_addr[DMEM_ADDR_WIDTH-1:2], 2'b00};
   assign dmem_wr_data = (r_state == S_WRITE)  ? r_wdata :
                         (r_state == S_RMW_WR) ? w_merge_data : '0;

   // r_we is kept for debug visibility of the latched request
   logic w_unused;
   assign w_unused = r_we;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ls_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_dmem_ls_arbiter                                               |
// | Brief   : table + randomized self-checking bench for dmem_ls_arbiter       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dmem_ls_arbiter;
   localparam int RW    = 32;
   localparam int AW    = 10;
   localparam int DEPTH = 1024;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
   logic [2:0]    m0_funct3 = '0, m1_funct3 = '0;
   logic [AW-1:0] m0_addr = '0, m1_addr = '0;
   logic [RW-1:0] m0_wdata = '0, m1_wdata = '0;
   logic          m0_done, m1_done, m0_err, m1_err, dmem_wr_en;
   logic [RW-1:0] m0_rdata, m1_rdata, dmem_wr_data;
   logic [RW-1:0] dmem_rd_data = '0;
   logic [AW-1:0] dmem_addr;

   always #5 clk = ~clk;

   dmem_ls_arbiter #(.REG_WIDTH(RW), .DMEM_ADDR_WIDTH(AW), .DMEM_DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_funct3(m0_funct3), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_funct3(m1_funct3), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .dmem_wr_en(dmem_wr_en), .dmem_addr(dmem_addr), .dmem_wr_data(dmem_wr_data),
      .dmem_rd_data(dmem_rd_data)
   );

   // Word DMEM: posedge write, negedge read; word n starts out holding n
   logic [31:0] dmem [0:255];
   initial begin
      for (int i = 0; i < 256; i++) dmem[i] = i;
      forever begin
         @(posedge clk);
         if (dmem_wr_en) dmem[dmem_addr[9:2]] = dmem_wr_data;
      end
   end
   always @(negedge clk) dmem_rd_data <= dmem[dmem_addr[9:2]];

   // Reference: byte-array memory plus round-robin history
   logic [7:0] refmem [0:DEPTH-1];
   bit         rr_last_m = 1'b1;
   int         n_vec = 0;
   int         n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic ref_exec(input bit we, input logic [2:0] f3, input logic [9:0] addr,
                           input logic [31:0] wd, output logic [31:0] rdata, output bit err,
                           output int lat, output int nwr, output logic [31:0] wword);
      int     size;
      longint val;
      bit     legal;
      legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      size  = 1 << f3[1:0];
      err   = !legal || (int'(addr) % size != 0) || (int'(addr) > DEPTH - 4);
      rdata = '0; nwr = 0; wword = '0;
      if (err) lat = 1;
      else if (!we) begin
         val = 0;
         for (int b = size - 1; b >= 0; b--) val = val * 256 + longint'(refmem[int'(addr) + b]);
         if (!f3[2] && size < 4 && val >= (longint'(1) << (8 * size - 1)))
            val = val - (longint'(1) << (8 * size));
         rdata = val[31:0];
         lat   = 2;
      end else begin
         for (int b = 0; b < size; b++) refmem[int'(addr) + b] = wd[8*b +: 8];
         for (int b = 0; b < 4; b++) wword[8*b +: 8] = refmem[(int'(addr) & ~3) + b];
         nwr = 1;
         lat = (size == 4) ? 2 : 3;
      end
   endtask

   task automatic drive(input bit port, input bit we, input logic [2:0] f3,
                        input logic [9:0] addr, input logic [31:0] wd);
      if (port == 1'b0) begin
         m0_req = 1; m0_we = we; m0_funct3 = f3; m0_addr = addr; m0_wdata = wd;
      end else begin
         m1_req = 1; m1_we = we; m1_funct3 = f3; m1_addr = addr; m1_wdata = wd;
      end
   endtask

   // Single transaction; expectations come from the table when use_tab is set
   task automatic do_txn(input string tag, input bit port, input bit we, input logic [2:0] f3,
                         input logic [9:0] addr, input logic [31:0] wd, input bit use_tab,
                         input logic [31:0] t_rd, input bit t_err, input int t_lat);
      logic [31:0] m_rd, wword, rd, wdv;
      logic [9:0]  wa;
      bit          m_err, got, er, other;
      int          m_lat, nwr, c, nwr_seen;
      ref_exec(we, f3, addr, wd, m_rd, m_err, m_lat, nwr, wword);
      if (use_tab) begin m_rd = t_rd; m_err = t_err; m_lat = t_lat; end
      drive(port, we, f3, addr, wd);
      got = 0; other = 0; nwr_seen = 0; c = -1; rd = '0; er = 0; wa = '0; wdv = '0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         if (dmem_wr_en) begin nwr_seen++; wa = dmem_addr; wdv = dmem_wr_data; end
         if (port ? m0_done : m1_done) other = 1;
         if (port ? m1_done : m0_done) begin
            got = 1; c = cyc;
            rd = port ? m1_rdata : m0_rdata;
            er = port ? m1_err : m0_err;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      if (port) m1_req = 0; else m0_req = 0;
      chk({tag, " done_seen"}, 32'(got), 32'd1);
      chk({tag, " latency"}, 32'(c), 32'(m_lat));
      chk({tag, " rdata"}, rd, m_rd);
      chk({tag, " err"}, 32'(er), 32'(m_err));
      chk({tag, " other_done"}, 32'(other), 32'd0);
      chk({tag, " write_cycles"}, 32'(nwr_seen), 32'(nwr));
      if (nwr_seen == 1 && nwr == 1) begin
         chk({tag, " wr_addr"}, 32'(wa), 32'(addr & 10'h3FC));
         chk({tag, " wr_data"}, wdv, wword);
      end
      rr_last_m = port;
   endtask

   // Both requesters present in the same cycle; the round-robin winner goes first
   task automatic do_pair(input string tag, input bit we0, input logic [2:0] f0,
                          input logic [9:0] a0, input logic [31:0] d0, input bit we1,
                          input logic [2:0] f1, input logic [9:0] a1, input logic [31:0] d1);
      bit          win, got0, got1, e0, e1, me0, me1;
      logic [31:0] r0, r1, mr0, mr1, ww;
      int          c0, c1, l0, l1, nw, lw, ll;
      win = ~rr_last_m;
      if (win == 1'b0) begin
         ref_exec(we0, f0, a0, d0, mr0, me0, l0, nw, ww);
         ref_exec(we1, f1, a1, d1, mr1, me1, l1, nw, ww);
         lw = l0; ll = l1;
      end else begin
         ref_exec(we1, f1, a1, d1, mr1, me1, l1, nw, ww);
         ref_exec(we0, f0, a0, d0, mr0, me0, l0, nw, ww);
         lw = l1; ll = l0;
      end
      drive(1'b0, we0, f0, a0, d0);
      drive(1'b1, we1, f1, a1, d1);
      got0 = 0; got1 = 0; c0 = -1; c1 = -1; r0 = '0; r1 = '0; e0 = 0; e1 = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         if (m0_done && !got0) begin got0 = 1; c0 = cyc; r0 = m0_rdata; e0 = m0_err; end
         if (m1_done && !got1) begin got1 = 1; c1 = cyc; r1 = m1_rdata; e1 = m1_err; end
         if (got0 && got1) break;
         @(posedge clk); #1;
         if (got0) m0_req = 0;
         if (got1) m1_req = 0;
      end
      @(posedge clk); #1;
      m0_req = 0; m1_req = 0;
      chk({tag, " m0_latency"}, 32'(c0), 32'(win == 1'b0 ? lw : lw + 1 + ll));
      chk({tag, " m1_latency"}, 32'(c1), 32'(win == 1'b1 ? lw : lw + 1 + ll));
      chk({tag, " m0_rdata"}, r0, mr0);
      chk({tag, " m1_rdata"}, r1, mr1);
      chk({tag, " m0_err"}, 32'(e0), 32'(me0));
      chk({tag, " m1_err"}, 32'(e1), 32'(me1));
      rr_last_m = ~win;
   endtask

   typedef struct {
      bit          port;
      bit          we;
      logic [2:0]  f3;
      logic [9:0]  addr;
      logic [31:0] wd;
      logic [31:0] rd;
      bit          err;
      int          lat;
   } vec_t;

   vec_t tab[$];

   initial begin
      bit          abort_seen, stray;
      logic [9:0]  a;
      logic [2:0]  f;
      for (int i = 0; i < DEPTH; i++) refmem[i] = 8'((i % 4 == 0) ? (i / 4) % 256 : 0);
      for (int i = 0; i < 256; i++) refmem[4 * i + 1] = 8'((i >> 8) & 8'hFF);

      tab.push_back('{0, 0, 3'd2, 10'd8,    32'h0,        32'h00000002, 0, 2});
      tab.push_back('{0, 1, 3'd0, 10'd5,    32'h80,       32'h0,        0, 3});
      tab.push_back('{0, 0, 3'd0, 10'd5,    32'h0,        32'hFFFFFF80, 0, 2});
      tab.push_back('{0, 0, 3'd4, 10'd5,    32'h0,        32'h00000080, 0, 2});
      tab.push_back('{0, 0, 3'd2, 10'd4,    32'h0,        32'h00008001, 0, 2});
      tab.push_back('{1, 0, 3'd1, 10'd4,    32'h0,        32'hFFFF8001, 0, 2});
      tab.push_back('{1, 0, 3'd5, 10'd4,    32'h0,        32'h00008001, 0, 2});
      tab.push_back('{0, 0, 3'd2, 10'd6,    32'h0,        32'h0,        1, 1});
      tab.push_back('{1, 1, 3'd1, 10'd3,    32'h1234,     32'h0,        1, 1});
      tab.push_back('{1, 0, 3'd2, 10'd1022, 32'h0,        32'h0,        1, 1});
      tab.push_back('{1, 0, 3'd0, 10'd1021, 32'h0,        32'h0,        1, 1});
      tab.push_back('{1, 1, 3'd2, 10'd1020, 32'hDEADBEEF, 32'h0,        0, 2});
      tab.push_back('{0, 0, 3'd2, 10'd1020, 32'h0,        32'hDEADBEEF, 0, 2});
      tab.push_back('{0, 0, 3'd3, 10'd0,    32'h0,        32'h0,        1, 1});
      tab.push_back('{1, 1, 3'd4, 10'd0,    32'hFFFFFFFF, 32'h0,        1, 1});
      tab.push_back('{1, 1, 3'd1, 10'd6,    32'h1234ABCD, 32'h0,        0, 3});
      tab.push_back('{0, 0, 3'd2, 10'd4,    32'h0,        32'hABCD8001, 0, 2});

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset m0_done", 32'(m0_done), 32'd0);
      chk("reset m1_done", 32'(m1_done), 32'd0);
      chk("reset rdata", m0_rdata | m1_rdata, 32'd0);
      chk("reset err", 32'(m0_err | m1_err), 32'd0);
      chk("reset wr_en", 32'(dmem_wr_en), 32'd0);
      chk("reset dmem_addr", 32'(dmem_addr), 32'd0);
      chk("reset wr_data", dmem_wr_data, 32'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      do_pair("tie1", 0, 3'd2, 10'd0, 32'h0, 0, 3'd2, 10'd4, 32'h0);
      do_pair("tie2", 0, 3'd2, 10'd0, 32'h0, 0, 3'd2, 10'd4, 32'h0);

      foreach (tab[i])
         do_txn($sformatf("vec%0d", i), tab[i].port, tab[i].we, tab[i].f3, tab[i].addr,
                tab[i].wd, 1'b1, tab[i].rd, tab[i].err, tab[i].lat);

      for (int i = 0; i < 120; i++) begin
         f = 3'($urandom_range(0, 7));
         a = 10'($urandom_range(0, DEPTH - 1));
         if ($urandom_range(0, 3) != 0) a = a & ~10'((1 << f[1:0]) - 1);
         if ($urandom_range(0, 9) == 0) a = 10'(1016 + $urandom_range(0, 7));
         do_txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                f, a, $urandom, 1'b0, 32'h0, 1'b0, 0);
      end
      for (int i = 0; i < 20; i++)
         do_pair($sformatf("rpair%0d", i),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 2)),
                 10'($urandom_range(0, 63) * 4), $urandom,
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 2)),
                 10'($urandom_range(64, 127) * 4), $urandom);

      // Abort an SH in its write cycle: no write, no done, round-robin reset
      drive(1'b0, 1'b1, 3'd1, 10'd8, 32'h00005555);
      abort_seen = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(negedge clk);
         if (dmem_wr_en) begin abort_seen = 1; break; end
      end
      chk("abort reached_rmw_wr", 32'(abort_seen), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("abort wr_en_drop", 32'(dmem_wr_en), 32'd0);
      chk("abort no_done", 32'(m0_done | m1_done), 32'd0);
      m0_req = 0;
      stray = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      for (int cyc = 0; cyc < 3; cyc++) begin
         @(negedge clk);
         if (m0_done || m1_done || dmem_wr_en) stray = 1;
      end
      chk("abort idle_after", 32'(stray), 32'd0);
      rr_last_m = 1'b1;
      @(posedge clk); #1;
      do_txn("abort readback", 1'b1, 1'b0, 3'd2, 10'd8, 32'h0, 1'b0, 32'h0, 1'b0, 0);
      rr_last_m = 1'b1;
      // Reset again so the tie test sees the post-reset round-robin state
      reset_n = 1'b0;
      #1;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      do_pair("post_reset_tie", 0, 3'd2, 10'd0, 32'h0, 0, 3'd2, 10'd4, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
